ahb_arbiter_rr: RTL and testbench

//  Parametrised AHB bus arbiter, successor to the fixed 16-master arbiter.
//  - Configurable master count; round-robin or fixed-priority mode.
//  - Adds a beat limit for forced handover, split-response masking and a default master.
//  - Sits between the masters' request/lock lines and the AHB address/data mux select.

---
 rtl/ahb_arbiter_rr_if.sv | 30 +++
 rtl/ahb_arbiter_rr.sv | 138 +++++++++++++
 tb/tb_ahb_arbiter_rr.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_rr_if.sv
// Bus-side signal bundle for the AHB arbiter: the masters' request and lock lines,
// the shared transfer/response lines it watches, and the grant/owner outputs.
// The arbiter uses the slave modport. The master modport is the mirror view used
// by the masters or by a testbench.
interface ahb_arbiter_rr_if #(
    parameter int NMASTERS = 16
);
    localparam int MW = $clog2(NMASTERS);

    logic [NMASTERS-1:0] HBUSREQx;
    logic [NMASTERS-1:0] HLOCKx;
    logic [NMASTERS-1:0] HSPLIT;
    logic                HREADY;
    logic [1:0]          HTRANS;
    logic [1:0]          HRESP;
    logic [NMASTERS-1:0] HGRANTx;
    logic [MW-1:0]       HMASTER;
    logic                HMASTLOCK;
    logic [NMASTERS-1:0] SPLITMASK;

    modport slave (
        input  HBUSREQx, HLOCKx, HSPLIT, HREADY, HTRANS, HRESP,
        output HGRANTx, HMASTER, HMASTLOCK, SPLITMASK
    );

    modport master (
        output HBUSREQx, HLOCKx, HSPLIT, HREADY, HTRANS, HRESP,
        input  HGRANTx, HMASTER, HMASTLOCK, SPLITMASK
    );
endinterface

// File: rtl/ahb_arbiter_rr.sv
// Parametrised AHB bus arbiter with round-robin or fixed-priority selection.
// It also provides a beat limit that forces handover, masking of masters that
// received a SPLIT, and a default master.
// The grant is registered and always one-hot. HMASTER and the data-phase owner
// follow the grant one and two HREADY edges later, matching the AHB pipeline.
module ahb_arbiter_rr #(
    parameter int NMASTERS       = 16,
    parameter int RR_MODE        = 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_arbiter_rr_if.slave    bus
);
    localparam int MW = $clog2(NMASTERS);
    localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);
    localparam logic [CW-1:0] MAXB     = CW'(MAX_BEATS);

    logic [NMASTERS-1:0] grant_q,     grant_d;
    logic [MW-1:0]       owner_q,     owner_d;
    logic [MW-1:0]       hmaster_q,   hmaster_d;
    logic                hmastlock_q, hmastlock_d;
    logic [MW-1:0]       dpOwner_q,   dpOwner_d;
    logic [NMASTERS-1:0] mask_q,      mask_d;
    logic [CW-1:0]       beat_q,      beat_d;
    logic [MW-1:0]       rrPtr_q,     rrPtr_d;

    logic [NMASTERS-1:0] eligible;
    logic                othersEligible;
    logic [CW-1:0]       beatInc;
    logic                hold;
    logic [MW-1:0]       winner;
    logic [MW-1:0]       newOwner;

    // Qualify requests with the split mask and decide whether the current owner keeps the bus.
    // The beat count used here includes the beat completing on this edge.
    // A MAX_BEATS limit therefore gives each owner exactly MAX_BEATS transfers.
    always_comb begin
        eligible       = bus.HBUSREQx & ~mask_q;
        othersEligible = |(eligible & ~grant_q);
        beatInc        = beat_q;
        if (bus.HTRANS[1] && (beat_q < MAXB)) begin
            beatInc = beat_q + 1'b1;
        end
        hold = (bus.HLOCKx[owner_q] & bus.HBUSREQx[owner_q]) |
               (eligible[owner_q] & ((MAX_BEATS == 0) | (beatInc < MAXB) | ~othersEligible));
    end

    // Pick the next owner.
    // Round-robin scans from the slot after the pointer and wraps; fixed mode scans from index 0.
    // If nothing is eligible, the default master is chosen.
    always_comb begin : arbSelect
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = DEF_IDX;
        for (int k = 1; k <= NMASTERS; k++) begin
            if (RR_MODE != 0) begin
                idx = int'(rrPtr_q) + k;
                if (idx >= NMASTERS) begin
                    idx = idx - NMASTERS;
                end
            end else begin
                idx = k - 1;
            end
            if (!found && eligible[idx[MW-1:0]]) begin
                found  = 1'b1;
                winner = idx[MW-1:0];
            end
        end
    end

    // Next-state for grant, pipeline owners, beat counter and split mask.
    // Everything except the split-mask clears is frozen while HREADY is low.
    always_comb begin
        grant_d     = grant_q;
        owner_d     = owner_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        dpOwner_d   = dpOwner_q;
        beat_d      = beat_q;
        rrPtr_d     = rrPtr_q;
        newOwner    = owner_q;
        mask_d      = mask_q & ~bus.HSPLIT;

        if (bus.HREADY) begin
            newOwner          = hold ? owner_q : winner;
            grant_d           = '0;
            grant_d[newOwner] = 1'b1;
            owner_d           = newOwner;
            hmaster_d         = owner_q;
            hmastlock_d       = bus.HLOCKx[owner_q];
            dpOwner_d         = hmaster_q;
            if (hold) begin
                beat_d = beatInc;
            end else begin
                beat_d  = '0;
                rrPtr_d = newOwner;
            end
            if (bus.HRESP == 2'b11) begin
                mask_d[dpOwner_q] = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset back to the default master.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q          <= '0;
            grant_q[DEF_IDX] <= 1'b1;
            owner_q          <= DEF_IDX;
            hmaster_q        <= DEF_IDX;
            hmastlock_q      <= 1'b0;
            dpOwner_q        <= DEF_IDX;
            mask_q           <= '0;
            beat_q           <= '0;
            rrPtr_q          <= DEF_IDX;
        end else begin
            grant_q          <= grant_d;
            owner_q          <= owner_d;
            hmaster_q        <= hmaster_d;
            hmastlock_q      <= hmastlock_d;
            dpOwner_q        <= dpOwner_d;
            mask_q           <= mask_d;
            beat_q           <= beat_d;
            rrPtr_q          <= rrPtr_d;
        end
    end

    assign bus.HGRANTx   = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;
    assign bus.SPLITMASK = mask_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Scoreboard bench for ahb_arbiter_rr.
// Instance A: 16 masters, round-robin, beat limit 2.
// Instance B: 8 masters, fixed priority, unlimited beats.
// Both instances see the same inputs but have separate resets.
// The stimulus pushes the values each edge must produce; the monitor pops one entry
// per clock edge and compares it against the addressed instance.
module tb_ahb_arbiter_rr;

    typedef struct {
        logic        rstnA;
        logic        rstnB;
        logic [15:0] req;
        logic [15:0] lock;
        logic [15:0] split;
        logic        ready;
        logic [1:0]  trans;
        logic [1:0]  resp;
    } stim_t;

    typedef struct {
        int          sel;
        string       name;
        bit          cg;
        logic [15:0] grant;
        bit          cm;
        logic [3:0]  master;
        bit          cl;
        logic        lock;
        bit          ck;
        logic [15:0] mask;
    } exp_t;

    logic clk;
    logic rstnA;
    logic rstnB;
    logic [15:0] drvReq;
    logic [15:0] drvLock;
    logic [15:0] drvSplit;
    logic        drvReady;
    logic [1:0]  drvTrans;
    logic [1:0]  drvResp;

    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;
    exp_t expQ[$];

    ahb_arbiter_rr_if #(.NMASTERS(16)) busA();
    ahb_arbiter_rr_if #(.NMASTERS(8))  busB();

    assign busA.HBUSREQx = drvReq;
    assign busA.HLOCKx   = drvLock;
    assign busA.HSPLIT   = drvSplit;
    assign busA.HREADY   = drvReady;
    assign busA.HTRANS   = drvTrans;
    assign busA.HRESP    = drvResp;
    assign busB.HBUSREQx = drvReq[7:0];
    assign busB.HLOCKx   = drvLock[7:0];
    assign busB.HSPLIT   = drvSplit[7:0];
    assign busB.HREADY   = drvReady;
    assign busB.HTRANS   = drvTrans;
    assign busB.HRESP    = drvResp;

    ahb_arbiter_rr #(.NMASTERS(16), .RR_MODE(1), .DEFAULT_MASTER(0), .MAX_BEATS(2)) dutA (
        .HCLK(clk), .HRESETn(rstnA), .bus(busA)
    );

    ahb_arbiter_rr #(.NMASTERS(8), .RR_MODE(0), .DEFAULT_MASTER(0), .MAX_BEATS(0)) dutB (
        .HCLK(clk), .HRESETn(rstnB), .bus(busB)
    );

    localparam logic [15:0] T2_GRANT  [8] = '{16'h0002, 16'h0002, 16'h0004, 16'h0004,
                                              16'h0008, 16'h0008, 16'h0002, 16'h0002};
    localparam logic [3:0]  T2_MASTER [8] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd1};
    localparam logic [15:0] T5_REQ    [5] = '{16'h0002, 16'h0004, 16'h0001, 16'h0006, 16'h0000};

    // Free-running bus clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(input int sel, input string name,
                                input bit cg, input logic [15:0] g,
                                input bit cm, input logic [3:0] m,
                                input bit cl, input logic l,
                                input bit ck, input logic [15:0] k);
        exp_t e;
        e.sel = sel; e.name = name;
        e.cg = cg; e.grant = g;
        e.cm = cm; e.master = m;
        e.cl = cl; e.lock = l;
        e.ck = ck; e.mask = k;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(negedge clk);
        rstnA    = s.rstnA;
        rstnB    = s.rstnB;
        drvReq   = s.req;
        drvLock  = s.lock;
        drvSplit = s.split;
        drvReady = s.ready;
        drvTrans = s.trans;
        drvResp  = s.resp;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [15:0] g;
        logic [3:0]  m;
        logic        l;
        logic [15:0] k;
        if (e.sel == 0) begin
            g = busA.HGRANTx;   m = busA.HMASTER;
            l = busA.HMASTLOCK; k = busA.SPLITMASK;
        end else begin
            g = {8'h00, busB.HGRANTx};  m = {1'b0, busB.HMASTER};
            l = busB.HMASTLOCK;         k = {8'h00, busB.SPLITMASK};
        end
        if (e.cg) begin
            checks++;
            if (g !== e.grant) begin
                failures++;
                $display("[TB] FAIL %s.HGRANTx got %h want %h", e.name, g, e.grant);
            end
        end
        if (e.cm) begin
            checks++;
            if (m !== e.master) begin
                failures++;
                $display("[TB] FAIL %s.HMASTER got %0d want %0d", e.name, m, e.master);
            end
        end
        if (e.cl) begin
            checks++;
            if (l !== e.lock) begin
                failures++;
                $display("[TB] FAIL %s.HMASTLOCK got %b want %b", e.name, l, e.lock);
            end
        end
        if (e.ck) begin
            checks++;
            if (k !== e.mask) begin
                failures++;
                $display("[TB] FAIL %s.SPLITMASK got %h want %h", e.name, k, e.mask);
            end
        end
    endtask

    // Monitor: one sample just after every rising edge; grant one-hot property plus the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                checks++;
                if (!$onehot(busA.HGRANTx)) begin
                    failures++;
                    $display("[TB] FAIL onehotA got %h want one-hot", busA.HGRANTx);
                end
                checks++;
                if (!$onehot(busB.HGRANTx)) begin
                    failures++;
                    $display("[TB] FAIL onehotB got %h want one-hot", busB.HGRANTx);
                end
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Directed scenarios.
    initial begin
        stim_t s;
        int    waitCycles;
        rstnA = 1'b0; rstnB = 1'b0;
        drvReq = '0; drvLock = '0; drvSplit = '0;
        drvReady = 1'b0; drvTrans = 2'd0; drvResp = 2'd0;
        s = '{rstnA: 1'b0, rstnB: 1'b0, req: 16'h0, lock: 16'h0, split: 16'h0,
              ready: 1'b0, trans: 2'd0, resp: 2'd0};

        $display("[TB] reset with all inputs low");
        applyStimulus(s, mk(0, "rstA", 1, 16'h0001, 1, 4'd0, 1, 1'b0, 1, 16'h0000));
        applyStimulus(s, mk(1, "rstB", 1, 16'h0001, 1, 4'd0, 1, 1'b0, 1, 16'h0000));
        started = 1'b1;

        $display("[TB] round-robin rotation with beat limit");
        s.rstnA = 1'b1; s.req = 16'h000E; s.trans = 2'd2; s.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(s, mk(0, $sformatf("rr%0d", i), 1, T2_GRANT[i], 1, T2_MASTER[i], 0, 1'b0, 0, 16'h0));
        end

        $display("[TB] locked owner keeps the bus");
        s.rstnA = 1'b0; s.req = 16'h0;
        applyStimulus(s, mk(0, "lockRst", 1, 16'h0001, 0, 4'd0, 0, 1'b0, 0, 16'h0));
        s.rstnA = 1'b1; s.req = 16'h0004; s.lock = 16'h0004;
        applyStimulus(s, mk(0, "lockGet", 1, 16'h0004, 1, 4'd0, 1, 1'b0, 0, 16'h0));
        s.req = 16'h000E;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(s, mk(0, $sformatf("lock%0d", i), 1, 16'h0004, 1, 4'd2, 1, 1'b1, 0, 16'h0));
        end
        s.lock = 16'h0;
        applyStimulus(s, mk(0, "unlock", 1, 16'h0008, 1, 4'd2, 0, 1'b0, 0, 16'h0));

        $display("[TB] split masking and release");
        s.rstnA = 1'b0; s.req = 16'h0; s.trans = 2'd0;
        applyStimulus(s, mk(0, "splitRst", 1, 16'h0001, 0, 4'd0, 0, 1'b0, 1, 16'h0000));
        s.rstnA = 1'b1; s.req = 16'h0008;
        applyStimulus(s, mk(0, "splitE1", 1, 16'h0008, 1, 4'd0, 0, 1'b0, 0, 16'h0));
        applyStimulus(s, mk(0, "splitE2", 1, 16'h0008, 1, 4'd3, 0, 1'b0, 0, 16'h0));
        s.req = 16'h000A;
        applyStimulus(s, mk(0, "splitE3", 1, 16'h0008, 0, 4'd0, 0, 1'b0, 1, 16'h0000));
        s.resp = 2'b11; s.split = 16'h0008;
        applyStimulus(s, mk(0, "splitSet", 1, 16'h0008, 0, 4'd0, 0, 1'b0, 1, 16'h0008));
        s.resp = 2'b00; s.split = 16'h0;
        applyStimulus(s, mk(0, "splitMove", 1, 16'h0002, 0, 4'd0, 0, 1'b0, 1, 16'h0008));
        s.split = 16'h0008;
        applyStimulus(s, mk(0, "splitClr", 1, 16'h0002, 0, 4'd0, 0, 1'b0, 1, 16'h0000));
        s.split = 16'h0; s.req = 16'h0008;
        applyStimulus(s, mk(0, "splitRegrant", 1, 16'h0008, 0, 4'd0, 0, 1'b0, 1, 16'h0000));

        $display("[TB] HREADY low freezes ownership");
        s.rstnA = 1'b0; s.req = 16'h0;
        applyStimulus(s, mk(0, "stallRst", 1, 16'h0001, 0, 4'd0, 0, 1'b0, 0, 16'h0));
        s.rstnA = 1'b1; s.req = 16'h0008;
        applyStimulus(s, mk(0, "stallE1", 1, 16'h0008, 0, 4'd0, 0, 1'b0, 0, 16'h0));
        applyStimulus(s, mk(0, "stallE2", 1, 16'h0008, 1, 4'd3, 0, 1'b0, 0, 16'h0));
        s.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s.req = T5_REQ[i];
            applyStimulus(s, mk(0, $sformatf("stall%0d", i), 1, 16'h0008, 1, 4'd3, 0, 1'b0, 0, 16'h0));
        end
        s.ready = 1'b1; s.req = 16'h0002;
        applyStimulus(s, mk(0, "resume", 1, 16'h0002, 1, 4'd3, 0, 1'b0, 0, 16'h0));
        applyStimulus(s, mk(0, "resume2", 1, 16'h0002, 1, 4'd1, 0, 1'b0, 0, 16'h0));

        $display("[TB] fixed priority, unlimited beats, mid-burst reset");
        s.rstnB = 1'b1; s.req = 16'h0021; s.trans = 2'd2;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(s, mk(1, $sformatf("fixHold%0d", i), 1, 16'h0001, 1, 4'd0, 0, 1'b0, 0, 16'h0));
        end
        s.req = 16'h0020;
        applyStimulus(s, mk(1, "fixMove", 1, 16'h0020, 1, 4'd0, 0, 1'b0, 0, 16'h0));
        applyStimulus(s, mk(1, "fixOwn", 1, 16'h0020, 1, 4'd5, 0, 1'b0, 0, 16'h0));
        applyStimulus(s, mk(1, "fixBurst", 1, 16'h0020, 1, 4'd5, 0, 1'b0, 0, 16'h0));
        s.rstnB = 1'b0;
        applyStimulus(s, mk(1, "fixRst", 1, 16'h0001, 1, 4'd0, 1, 1'b0, 1, 16'h0000));
        s.rstnB = 1'b1; s.req = 16'h0;
        applyStimulus(s, mk(1, "fixIdle", 1, 16'h0001, 1, 4'd0, 0, 1'b0, 0, 16'h0));

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
